// File: rtl/btn_pkg.sv
// Shared state encoding for the button gesture decoder.
package btn_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_PRESS1 = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT2  = 3'd2;
    localparam logic [ST_W-1:0] ST_PRESS2 = 3'd3;
    localparam logic [ST_W-1:0] ST_HELD   = 3'd4;

    typedef enum logic [ST_W-1:0] {
        StIdle   = ST_IDLE,
        StPress1 = ST_PRESS1,
        StWait2  = ST_WAIT2,
        StPress2 = ST_PRESS2,
        StHeld   = ST_HELD
    } btn_state_e;

endpackage

// File: rtl/ce_tick_counter.sv
// Counts CE ticks; synchronous clear wins over counting. TC flags the tick at CNT == N-1.
module ce_tick_counter #(
    parameter int unsigned W = 10,
    parameter int unsigned N = 500
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         CE,
    output logic [W-1:0] CNT,
    output logic         TC
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q;

    // Tick counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (CLR) begin
            cnt_q <= '0;
        end else if (CE) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign CNT = cnt_q;
    assign TC  = CE & (cnt_q == LAST);

endmodule

// File: rtl/btn_event_decoder.sv
// Turns debounced button activity into one-cycle click / double / long / repeat strobes.
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int unsigned LONG_TICKS = 500,
    parameter int unsigned DBL_TICKS  = 250,
    parameter int unsigned RPT_TICKS  = 100,
    parameter int unsigned CNT_W      = 10
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic            BTN_LVL,
    input  logic            BTN_PRESS,
    output logic            SHORT_CEO,
    output logic            DOUBLE_CEO,
    output logic            LONG_CEO,
    output logic            REPEAT_CEO,
    output logic [ST_W-1:0] STATE
);

    localparam logic [CNT_W-1:0] DBL_LAST = CNT_W'(DBL_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_TICKS - 1);

    btn_state_e       state_q, state_d;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             rpt_clr;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt;
    logic             long_tc;
    logic             dbl_tc;
    logic             rpt_tc;

    // One shared counter; the long threshold comes from its TC, the others are decoded here.
    ce_tick_counter #(
        .W (CNT_W),
        .N (LONG_TICKS)
    ) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .CLR (cnt_clr),
        .CE  (CE),
        .CNT (cnt),
        .TC  (long_tc)
    );

    assign dbl_tc  = CE & (cnt == DBL_LAST);
    assign rpt_tc  = CE & (cnt == RPT_LAST);
    // Any state change restarts the tick count, as does each repeat strobe.
    assign cnt_clr = rpt_clr | (state_d != state_q);

    // Next-state and strobe decode; releases and presses beat same-cycle timeouts
    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        rpt_clr  = 1'b0;
        case (state_q)
            StIdle: begin
                if (BTN_PRESS) state_d = StPress1;
            end
            StPress1: begin
                if (!BTN_LVL) begin
                    state_d = StWait2;
                end else if (long_tc) begin
                    state_d = StHeld;
                    long_d  = 1'b1;
                end
            end
            StWait2: begin
                if (BTN_PRESS) begin
                    state_d = StPress2;
                end else if (dbl_tc) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                end
            end
            StPress2: begin
                if (!BTN_LVL) begin
                    state_d  = StIdle;
                    double_d = 1'b1;
                end
            end
            StHeld: begin
                if (!BTN_LVL) begin
                    state_d = StIdle;
                end else if (rpt_tc) begin
                    repeat_d = 1'b1;
                    rpt_clr  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered strobes
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
        end
    end

    assign SHORT_CEO  = short_q;
    assign DOUBLE_CEO = double_q;
    assign LONG_CEO   = long_q;
    assign REPEAT_CEO = repeat_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Bench for btn_event_decoder: gesture table, corner sequences, reset cases, random stream.
module tb_btn_event_decoder;

    localparam int LONG = 8;
    localparam int DBL  = 4;
    localparam int RPT  = 3;

    localparam int P_IDLE   = 0;
    localparam int P_PRESS1 = 1;
    localparam int P_WAIT2  = 2;
    localparam int P_PRESS2 = 3;
    localparam int P_HELD   = 4;

    typedef struct {
        int hold1;
        int gap;
        int hold2;
        int n_short;
        int n_double;
        int n_long;
        int n_repeat;
    } gesture_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CE = 1'b0;
    logic       BTN_LVL = 1'b0;
    logic       BTN_PRESS = 1'b0;
    logic       SHORT_CEO, DOUBLE_CEO, LONG_CEO, REPEAT_CEO;
    logic [2:0] STATE;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int m_phase = P_IDLE;
    int m_ticks = 0;
    bit e_s, e_d, e_l, e_r;
    bit prev_lvl = 1'b0;
    bit ce_ph = 1'b0;
    logic [3:0] pv = '0;
    int c_s, c_d, c_l, c_r;

    btn_event_decoder #(
        .LONG_TICKS (LONG),
        .DBL_TICKS  (DBL),
        .RPT_TICKS  (RPT),
        .CNT_W      (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CE         (CE),
        .BTN_LVL    (BTN_LVL),
        .BTN_PRESS  (BTN_PRESS),
        .SHORT_CEO  (SHORT_CEO),
        .DOUBLE_CEO (DOUBLE_CEO),
        .LONG_CEO   (LONG_CEO),
        .REPEAT_CEO (REPEAT_CEO),
        .STATE      (STATE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_ticks = 0;
        {e_s, e_d, e_l, e_r} = '0;
        pv = '0;
    endtask

    // Gesture rules in terms of ticks elapsed since entering the current phase.
    task automatic model_step(input bit lvl, input bit press, input bit ce);
        int nxt;
        nxt = m_phase;
        {e_s, e_d, e_l, e_r} = '0;
        case (m_phase)
            P_IDLE: if (press) nxt = P_PRESS1;
            P_PRESS1: begin
                if (!lvl) nxt = P_WAIT2;
                else if (ce) begin
                    m_ticks++;
                    if (m_ticks == LONG) begin nxt = P_HELD; e_l = 1'b1; end
                end
            end
            P_WAIT2: begin
                if (press) nxt = P_PRESS2;
                else if (ce) begin
                    m_ticks++;
                    if (m_ticks == DBL) begin nxt = P_IDLE; e_s = 1'b1; end
                end
            end
            P_PRESS2: if (!lvl) begin nxt = P_IDLE; e_d = 1'b1; end
            default: begin
                if (!lvl) nxt = P_IDLE;
                else if (ce) begin
                    m_ticks++;
                    if (m_ticks % RPT == 0) e_r = 1'b1;
                end
            end
        endcase
        if (nxt != m_phase) m_ticks = 0;
        m_phase = nxt;
    endtask

    task automatic check_outputs();
        logic [3:0] cur;
        cur = {SHORT_CEO, DOUBLE_CEO, LONG_CEO, REPEAT_CEO};
        check_eq($sformatf("cycle %0d state/strobes {st,s,d,l,r}", cyc),
                 int'({STATE, cur}), int'({3'(m_phase), e_s, e_d, e_l, e_r}));
        check_eq($sformatf("cycle %0d strobe onehot", cyc), int'($countones(cur) > 1), 0);
        check_eq($sformatf("cycle %0d strobe width", cyc), int'(cur & pv), 0);
        pv = cur;
        c_s += int'(SHORT_CEO);
        c_d += int'(DOUBLE_CEO);
        c_l += int'(LONG_CEO);
        c_r += int'(REPEAT_CEO);
    endtask

    task automatic step(input bit lvl, input bit press, input bit ce);
        BTN_LVL = lvl;
        BTN_PRESS = press;
        CE = ce;
        prev_lvl = lvl;
        model_step(lvl, press, ce);
        @(posedge CLK);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic auto_step(input bit lvl, input bit ce);
        step(lvl, lvl & ~prev_lvl, ce);
    endtask

    // CE on every second clock
    task automatic tick_cycles(input bit lvl, input int nticks);
        for (int i = 0; i < 2 * nticks; i++) begin
            ce_ph = ~ce_ph;
            auto_step(lvl, ce_ph);
        end
    endtask

    task automatic clear_counts();
        c_s = 0; c_d = 0; c_l = 0; c_r = 0;
    endtask

    task automatic run_row(input gesture_t g, input string tag);
        clear_counts();
        tick_cycles(1'b1, g.hold1);
        if (g.hold2 > 0) begin
            tick_cycles(1'b0, g.gap);
            tick_cycles(1'b1, g.hold2);
        end
        tick_cycles(1'b0, 10);
        check_eq({tag, " short count"}, c_s, g.n_short);
        check_eq({tag, " double count"}, c_d, g.n_double);
        check_eq({tag, " long count"}, c_l, g.n_long);
        check_eq({tag, " repeat count"}, c_r, g.n_repeat);
    endtask

    gesture_t rows[7];

    initial begin
        bit seen;
        bit lvl;
        bit prs;
        rows[0] = '{hold1: 3,  gap: 0, hold2: 0,  n_short: 1, n_double: 0, n_long: 0, n_repeat: 0};
        rows[1] = '{hold1: 3,  gap: 2, hold2: 20, n_short: 0, n_double: 1, n_long: 0, n_repeat: 0};
        rows[2] = '{hold1: 16, gap: 0, hold2: 0,  n_short: 0, n_double: 0, n_long: 1, n_repeat: 2};
        rows[3] = '{hold1: 1,  gap: 1, hold2: 1,  n_short: 0, n_double: 1, n_long: 0, n_repeat: 0};
        rows[4] = '{hold1: 7,  gap: 0, hold2: 0,  n_short: 1, n_double: 0, n_long: 0, n_repeat: 0};
        rows[5] = '{hold1: 30, gap: 0, hold2: 0,  n_short: 0, n_double: 0, n_long: 1, n_repeat: 7};
        rows[6] = '{hold1: 3,  gap: 6, hold2: 3,  n_short: 2, n_double: 0, n_long: 0, n_repeat: 0};
        clear_counts();
        model_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        RST = 1'b0;

        // Gesture table
        for (int i = 0; i < 7; i++) run_row(rows[i], $sformatf("row%0d", i));

        // Release on the long tick, then press on the double-click timeout tick
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        check_eq("release-on-long-tick state", int'(STATE), P_WAIT2);
        check_eq("release-on-long-tick LONG_CEO", int'(LONG_CEO), 0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1);
        check_eq("press-on-dbl-tick state", int'(STATE), P_PRESS2);
        check_eq("press-on-dbl-tick SHORT_CEO", int'(SHORT_CEO), 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("second release DOUBLE_CEO", int'(DOUBLE_CEO), 1);
        tick_cycles(1'b0, 6);

        // Asynchronous reset while HELD, landing on the LONG_CEO cycle
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            ce_ph = ~ce_ph;
            auto_step(1'b1, ce_ph);
            seen = LONG_CEO;
        end
        check_eq("reached long press before reset", int'(seen), 1);
        RST = 1'b1;
        #1;
        check_eq("async reset in HELD outputs", int'({STATE, SHORT_CEO, DOUBLE_CEO, LONG_CEO,
                 REPEAT_CEO}), 0);
        model_reset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        clear_counts();
        tick_cycles(1'b1, 5);
        tick_cycles(1'b0, 10);
        check_eq("strobes after HELD reset", c_s + c_d + c_l + c_r, 0);

        // Asynchronous reset pulse while in WAIT2
        tick_cycles(1'b1, 2);
        tick_cycles(1'b0, 1);
        check_eq("in WAIT2 before reset", int'(STATE), P_WAIT2);
        RST = 1'b1;
        #2;
        check_eq("async reset in WAIT2 STATE", int'(STATE), P_IDLE);
        RST = 1'b0;
        model_reset();
        clear_counts();
        tick_cycles(1'b0, 10);
        check_eq("no SHORT after WAIT2 reset", c_s, 0);
        run_row(rows[0], "click after reset");

        // Random stream with CE jitter and occasional spurious presses while held
        for (int i = 0; i < 4000; i++) begin
            lvl = prev_lvl;
            if ($urandom_range(0, 9) == 0) lvl = ~lvl;
            prs = lvl & ~prev_lvl;
            if (lvl && prev_lvl && $urandom_range(0, 49) == 0) prs = 1'b1;
            step(lvl, prs, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
